// File: rtl/alarm_pkg.sv
// Shared types, parameter indices and default intervals for the alarm controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alarm_pkg;

    // State encoding is visible on state_out, so the values are fixed.
    typedef enum logic [2:0] {
        ARMED       = 3'd0,
        TRIGGERED   = 3'd1,
        SOUND_ALARM = 3'd2,
        DISARMED    = 3'd3,
        WAIT_OPEN   = 3'd4,
        WAIT_CLOSE  = 3'd5,
        ARM_DELAY   = 3'd6
    } state_t;

    // Indices into the interval register file.
    localparam logic [1:0] P_ARM    = 2'd0;
    localparam logic [1:0] P_DRIVER = 2'd1;
    localparam logic [1:0] P_PASS   = 2'd2;
    localparam logic [1:0] P_ALARM  = 2'd3;

    // Default intervals in seconds.
    localparam logic [3:0] T_ARM_DELAY_DEF = 4'd6;
    localparam logic [3:0] T_DRIVER_DEF    = 4'd8;
    localparam logic [3:0] T_PASSENGER_DEF = 4'd15;
    localparam logic [3:0] T_ALARM_ON_DEF  = 4'd10;

    // A zero interval would make the timer expire immediately; store it as one second.
    function automatic logic [3:0] clamp_interval(input logic [3:0] value);
        return (value == 4'd0) ? 4'd1 : value;
    endfunction

    // Power-on value of each interval register.
    function automatic logic [3:0] param_default(input logic [1:0] sel);
        logic [3:0] value;
        case (sel)
            P_ARM:    value = T_ARM_DELAY_DEF;
            P_DRIVER: value = T_DRIVER_DEF;
            P_PASS:   value = T_PASSENGER_DEF;
            default:  value = T_ALARM_ON_DEF;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/alarm_time_params.sv
// Four reprogrammable 4-bit interval registers with reset defaults and zero clamping.
// Latency: write lands on the next clock edge; read port is combinational.
// Backpressure: none; a write strobe is always accepted.
module alarm_time_params
    import alarm_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_sel,
    input  logic [3:0] wr_value,
    input  logic [1:0] rd_sel,
    output logic [3:0] rd_value
);

    logic [3:0] regs [4];

    // Register file: defaults on reset, clamped write otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= param_default(2'(i));
            end
        end else if (wr_en) begin
            regs[wr_sel] <= clamp_interval(wr_value);
        end
    end

    // The FSM reads the interval it is about to start in the same cycle it decides to start.
    assign rd_value = regs[rd_sel];

endmodule

// File: rtl/alarm_controller.sv
// Anti-theft sequencer driving the shared countdown timer, the siren and the status LED.
// Latency: every output is registered; start_timer rises one cycle after the causing input.
// Backpressure: none; inputs are sampled every cycle, timer events arrive as 1-cycle pulses.
module alarm_controller
    import alarm_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       driver_door,
    input  logic       passenger_door,
    input  logic       reprogram,
    input  logic [1:0] param_sel,
    input  logic [3:0] param_value,
    input  logic       expired_pulse,
    input  logic       one_hz,
    output logic       start_timer,
    output logic [3:0] interval_value,
    output logic       siren,
    output logic       status_led,
    output logic [2:0] state_out
);

    state_t     state;
    state_t     state_nxt;
    logic       run_valid;
    logic       run_valid_nxt;
    logic       start_nxt;
    logic [1:0] sel_nxt;
    logic       siren_nxt;
    logic       led_nxt;
    logic [3:0] param_rd;
    logic       any_door;
    logic       expiry;

    alarm_time_params u_params (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (reprogram),
        .wr_sel   (param_sel),
        .wr_value (param_value),
        .rd_sel   (sel_nxt),
        .rd_value (param_rd)
    );

    assign any_door = driver_door | passenger_door;

    // An expiry only counts for a run we own. While start_timer is high the timer is
    // reloading, so any pulse seen then belongs to the previous run and is dropped.
    assign expiry = expired_pulse & run_valid & ~start_timer;

    // Next-state, timer start and output decisions.
    always_comb begin
        state_nxt     = state;
        run_valid_nxt = run_valid;
        start_nxt     = 1'b0;
        sel_nxt       = P_ARM;
        siren_nxt     = siren;
        led_nxt       = status_led;

        if (reprogram) begin
            // A parameter write re-arms and abandons any running interval.
            state_nxt     = ARMED;
            run_valid_nxt = 1'b0;
            siren_nxt     = 1'b0;
        end else if (ignition && (state != DISARMED)) begin
            // The owner's key always wins over the alarm sequence.
            state_nxt     = DISARMED;
            run_valid_nxt = 1'b0;
            siren_nxt     = 1'b0;
            led_nxt       = 1'b0;
        end else begin
            if (expiry) begin
                run_valid_nxt = 1'b0;
            end

            case (state)
                ARMED: begin
                    siren_nxt = 1'b0;
                    if (one_hz) begin
                        led_nxt = ~status_led;
                    end
                    // Driver door takes precedence when both open together.
                    if (driver_door) begin
                        state_nxt = TRIGGERED;
                        start_nxt = 1'b1;
                        sel_nxt   = P_DRIVER;
                        led_nxt   = 1'b1;
                    end else if (passenger_door) begin
                        state_nxt = TRIGGERED;
                        start_nxt = 1'b1;
                        sel_nxt   = P_PASS;
                        led_nxt   = 1'b1;
                    end
                end

                TRIGGERED: begin
                    led_nxt   = 1'b1;
                    siren_nxt = 1'b0;
                    if (expiry) begin
                        state_nxt = SOUND_ALARM;
                        siren_nxt = 1'b1;
                    end
                end

                SOUND_ALARM: begin
                    siren_nxt = 1'b1;
                    led_nxt   = 1'b1;
                    if (any_door) begin
                        // Reopening during the hold period cancels it; the hold
                        // restarts from scratch once everything is closed again.
                        if (run_valid) begin
                            run_valid_nxt = 1'b0;
                        end
                    end else if (!run_valid) begin
                        start_nxt = 1'b1;
                        sel_nxt   = P_ALARM;
                    end else if (expiry) begin
                        state_nxt = ARMED;
                        siren_nxt = 1'b0;
                    end
                end

                DISARMED: begin
                    siren_nxt = 1'b0;
                    led_nxt   = 1'b0;
                    if (!ignition) begin
                        state_nxt = WAIT_OPEN;
                    end
                end

                WAIT_OPEN: begin
                    siren_nxt = 1'b0;
                    led_nxt   = 1'b0;
                    if (driver_door) begin
                        state_nxt = WAIT_CLOSE;
                    end
                end

                WAIT_CLOSE: begin
                    siren_nxt = 1'b0;
                    led_nxt   = 1'b0;
                    if (!any_door) begin
                        state_nxt = ARM_DELAY;
                        start_nxt = 1'b1;
                        sel_nxt   = P_ARM;
                    end
                end

                ARM_DELAY: begin
                    siren_nxt = 1'b0;
                    led_nxt   = 1'b0;
                    if (any_door) begin
                        state_nxt     = WAIT_CLOSE;
                        run_valid_nxt = 1'b0;
                    end else if (expiry) begin
                        state_nxt = ARMED;
                    end
                end

                default: begin
                    state_nxt     = ARMED;
                    run_valid_nxt = 1'b0;
                    siren_nxt     = 1'b0;
                    led_nxt       = 1'b0;
                end
            endcase

            // A fresh start owns the timer regardless of any expiry this cycle.
            if (start_nxt) begin
                run_valid_nxt = 1'b1;
            end
        end
    end

    // State, run ownership and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ARMED;
            run_valid      <= 1'b0;
            start_timer    <= 1'b0;
            interval_value <= 4'd0;
            siren          <= 1'b0;
            status_led     <= 1'b0;
        end else begin
            state       <= state_nxt;
            run_valid   <= run_valid_nxt;
            start_timer <= start_nxt;
            if (start_nxt) begin
                interval_value <= param_rd;
            end
            siren      <= siren_nxt;
            status_led <= led_nxt;
        end
    end

    assign state_out = 3'(state);

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller with a behavioural countdown timer.
// Latency: checks start_timer exactly one cycle after its cause.
// Backpressure: n/a.
module tb_alarm_controller;
    import alarm_pkg::*;

    localparam int ONE_HZ_PERIOD = 4;
    localparam int K_STATE = 0;
    localparam int K_SIREN = 1;
    localparam int K_LED   = 2;
    localparam int K_IVAL  = 3;
    localparam int K_VALUE = 4;

    logic       clock = 1'b0;
    logic       reset, ignition, driver_door, passenger_door, reprogram;
    logic [1:0] param_sel;
    logic [3:0] param_value;
    logic       expired_pulse, one_hz;
    logic       start_timer, siren, status_led;
    logic [3:0] interval_value;
    logic [2:0] state_out;

    logic tmr_exp = 1'b0;
    logic tmr_1hz = 1'b0;
    logic inj_exp = 1'b0;
    logic done    = 1'b0;

    assign expired_pulse = tmr_exp | inj_exp;
    assign one_hz        = tmr_1hz;

    alarm_controller dut (
        .clock          (clock),
        .reset          (reset),
        .ignition       (ignition),
        .driver_door    (driver_door),
        .passenger_door (passenger_door),
        .reprogram      (reprogram),
        .param_sel      (param_sel),
        .param_value    (param_value),
        .expired_pulse  (expired_pulse),
        .one_hz         (one_hz),
        .start_timer    (start_timer),
        .interval_value (interval_value),
        .siren          (siren),
        .status_led     (status_led),
        .state_out      (state_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int cyc; int iv; } start_exp_t;
    typedef struct { int cyc; int kind; int val; int act; string name; } probe_t;
    start_exp_t sq[$];
    probe_t     pq[$];

    int checks = 0;
    int fails  = 0;
    int prm [4];

    // Behavioural countdown timer: reloads on start_timer, one_hz every ONE_HZ_PERIOD clocks.
    initial begin
        int presc;
        int cnt;
        bit running;
        bit st;
        logic [3:0] iv;
        presc = 0; cnt = 0; running = 0;
        forever begin
            @(negedge clock);
            st = (start_timer === 1'b1);
            iv = interval_value;
            @(posedge clock);
            #1;
            tmr_1hz = 1'b0;
            tmr_exp = 1'b0;
            if (st) begin
                cnt = int'(iv); presc = 0; running = 1;
            end else begin
                presc++;
                if (presc == ONE_HZ_PERIOD) begin
                    presc = 0;
                    tmr_1hz = 1'b1;
                    if (running) begin
                        cnt--;
                        if (cnt <= 0) begin tmr_exp = 1'b1; running = 0; end
                    end
                end
            end
        end
    end

    // Monitor: pops expected starts and probes, compares against the DUT.
    initial begin
        start_exp_t se;
        probe_t p;
        int act;
        forever begin
            @(negedge clock);
            while (sq.size() > 0 && sq[0].cyc < cyc) begin
                se = sq.pop_front();
                checks++; fails++;
                $display("FAIL start_missing: no start_timer at cyc=%0d, required interval=%0d", se.cyc, se.iv);
            end
            if (start_timer === 1'b1) begin
                checks++;
                if (sq.size() == 0) begin
                    fails++;
                    $display("FAIL start_unexpected: start_timer at cyc=%0d interval=%0d, required none", cyc, interval_value);
                end else begin
                    se = sq.pop_front();
                    if (se.cyc != cyc || int'(interval_value) != se.iv) begin
                        fails++;
                        $display("FAIL start_timer: got cyc=%0d interval=%0d, required cyc=%0d interval=%0d",
                                 cyc, interval_value, se.cyc, se.iv);
                    end
                end
            end
            while (pq.size() > 0 && pq[0].cyc <= cyc) begin
                p = pq.pop_front();
                case (p.kind)
                    K_STATE: act = int'(state_out);
                    K_SIREN: act = int'(siren);
                    K_LED:   act = int'(status_led);
                    K_IVAL:  act = int'(interval_value);
                    default: act = p.act;
                endcase
                checks++;
                if (act != p.val) begin
                    fails++;
                    $display("FAIL %s: got %0d, required %0d (cyc=%0d)", p.name, act, p.val, cyc);
                end
            end
            if (done) begin
                checks++;
                if (sq.size() != 0) begin
                    fails++;
                    $display("FAIL start_pending: %0d expected starts never seen, required 0", sq.size());
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
                $finish;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clock); #2; end
    endtask

    task automatic probe(input int kind, input int val, input string name);
        probe_t p;
        p.cyc = cyc; p.kind = kind; p.val = val; p.act = 0; p.name = name;
        pq.push_back(p);
    endtask

    task automatic probe_value(input int act, input int val, input string name);
        probe_t p;
        p.cyc = cyc; p.kind = K_VALUE; p.val = val; p.act = act; p.name = name;
        pq.push_back(p);
    endtask

    // Call in the cycle the causing input is driven.
    task automatic expect_start(input int idx);
        start_exp_t e;
        e.cyc = cyc + 1; e.iv = prm[idx];
        sq.push_back(e);
    endtask

    task automatic wait_state(input state_t target, input int budget, input string name);
        int n = 0;
        while (int'(state_out) != int'(target) && n < budget) begin tick(1); n++; end
        probe(K_STATE, int'(target), name);
    endtask

    task automatic do_reset();
        reset = 1'b1; ignition = 1'b0; driver_door = 1'b0; passenger_door = 1'b0;
        reprogram = 1'b0; inj_exp = 1'b0;
        tick(1);
        reset = 1'b0;
        prm[0] = 6; prm[1] = 8; prm[2] = 15; prm[3] = 10;
        probe(K_STATE, int'(ARMED), "reset_state");
        probe(K_SIREN, 0, "reset_siren");
        probe(K_LED, 0, "reset_led");
        probe(K_IVAL, 0, "reset_interval");
    endtask

    // Write a parameter and close both doors in the same cycle; model clamps zero to one.
    task automatic reprog(input int sel, input int val);
        reprogram = 1'b1; param_sel = 2'(sel); param_value = 4'(val);
        driver_door = 1'b0; passenger_door = 1'b0;
        tick(1);
        reprogram = 1'b0;
        prm[sel] = (val == 0) ? 1 : val;
        probe(K_STATE, int'(ARMED), "reprog_armed");
        probe(K_SIREN, 0, "reprog_siren");
    endtask

    task automatic go_arm_delay();
        ignition = 1'b1; tick(1);
        ignition = 1'b0; tick(1);
        driver_door = 1'b1; tick(2);
        probe(K_STATE, int'(WAIT_CLOSE), "path_wait_close");
        driver_door = 1'b0; expect_start(P_ARM); tick(1);
        probe(K_STATE, int'(ARM_DELAY), "path_arm_delay");
    endtask

    initial begin
        int r, t0;
        reset = 1'b1; ignition = 1'b0; driver_door = 1'b0; passenger_door = 1'b0;
        reprogram = 1'b0; param_sel = 2'd0; param_value = 4'd0;
        tick(2);

        // Driver trigger leads to the siren after the driver grace period.
        do_reset();
        tick($urandom_range(1, 4));
        driver_door = 1'b1; expect_start(P_DRIVER); tick(1);
        probe(K_STATE, int'(TRIGGERED), "trig_state");
        probe(K_LED, 1, "trig_led");
        wait_state(SOUND_ALARM, 60, "sound_after_driver");
        probe(K_SIREN, 1, "sound_siren");

        // Siren hold: close, reopen mid-hold (cancel), close again, expire back to ARMED.
        tick(2);
        driver_door = 1'b0; expect_start(P_ALARM); tick(1);
        tick(20);
        passenger_door = 1'b1; tick(1);
        tick(50);
        probe(K_STATE, int'(SOUND_ALARM), "hold_cancelled_state");
        probe(K_SIREN, 1, "hold_cancelled_siren");
        passenger_door = 1'b0; expect_start(P_ALARM); tick(1);
        wait_state(ARMED, 60, "hold_expired_armed");
        probe(K_SIREN, 0, "hold_expired_siren");

        // Door priority and reprogrammed intervals.
        driver_door = 1'b1; passenger_door = 1'b1; expect_start(P_DRIVER); tick(1);
        probe(K_STATE, int'(TRIGGERED), "both_doors_trig");
        tick(2);
        reprog(1, 3);
        driver_door = 1'b1; expect_start(P_DRIVER); tick(1);
        tick(1);
        reprog(2, 0);
        passenger_door = 1'b1; expect_start(P_PASS); tick(1);
        probe(K_STATE, int'(TRIGGERED), "pass_trig");
        reprog(3, 5);
        tick(40);
        probe(K_STATE, int'(ARMED), "stale_after_reprog");
        probe(K_SIREN, 0, "stale_after_reprog_siren");

        // Randomized triggers interleaved with random reprogramming.
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 2);
            driver_door    = (r != 1);
            passenger_door = (r != 0);
            expect_start((r == 1) ? P_PASS : P_DRIVER);
            tick(1);
            probe(K_STATE, int'(TRIGGERED), "rand_trig");
            tick($urandom_range(1, 3));
            reprog($urandom_range(0, 3), $urandom_range(0, 15));
        end

        // Ignition disarms a triggered alarm, then the re-arm path with an interrupted delay.
        do_reset();
        driver_door = 1'b1; expect_start(P_DRIVER); tick(1);
        tick(3);
        ignition = 1'b1; tick(1);
        probe(K_STATE, int'(DISARMED), "disarm_state");
        probe(K_SIREN, 0, "disarm_siren");
        probe(K_LED, 0, "disarm_led");
        tick(40);
        probe(K_STATE, int'(DISARMED), "disarm_hold_state");
        probe(K_SIREN, 0, "disarm_hold_siren");
        ignition = 1'b0; tick(1);
        probe(K_STATE, int'(WAIT_OPEN), "wait_open");
        tick(1);
        probe(K_STATE, int'(WAIT_CLOSE), "wait_close");
        driver_door = 1'b0; expect_start(P_ARM); tick(1);
        probe(K_STATE, int'(ARM_DELAY), "arm_delay");
        tick(12);
        passenger_door = 1'b1; tick(1);
        probe(K_STATE, int'(WAIT_CLOSE), "arm_delay_cancel");
        tick($urandom_range(1, 5));
        passenger_door = 1'b0; expect_start(P_ARM); tick(1);
        probe(K_STATE, int'(ARM_DELAY), "arm_delay_restart");
        wait_state(ARMED, 45, "arm_delay_done");
        probe(K_LED, 0, "arm_delay_done_led");

        // Expiry pulses injected where they must be ignored.
        do_reset();
        tick(2);
        inj_exp = 1'b1; tick(1); inj_exp = 1'b0;
        probe(K_STATE, int'(ARMED), "inject_armed");
        ignition = 1'b1; tick(1);
        inj_exp = 1'b1; tick(1); inj_exp = 1'b0;
        probe(K_STATE, int'(DISARMED), "inject_disarmed");
        do_reset();
        tick(1);
        t0 = cyc;
        driver_door = 1'b1; inj_exp = 1'b1; expect_start(P_DRIVER); tick(1);
        inj_exp = 1'b1; tick(1); inj_exp = 1'b0;
        probe(K_STATE, int'(TRIGGERED), "inject_on_start");
        wait_state(SOUND_ALARM, 60, "inject_run_sound");
        probe_value(cyc - t0, 4 * 8 + 3, "inject_run_length");

        // Reset in the middle of an arm delay with a reprogrammed interval.
        do_reset();
        reprog(0, 2);
        go_arm_delay();
        tick(3);
        do_reset();
        tick(20);
        probe(K_STATE, int'(ARMED), "stale_after_reset");
        go_arm_delay();
        wait_state(ARMED, 45, "default_arm_delay_done");
        driver_door = 1'b1; expect_start(P_DRIVER); tick(1);
        tick(2);

        done = 1'b1;
    end

endmodule
